// File: rtl/core_pkg.sv
// Shared core definitions: hazard sequencer state encoding, NOP and the opcodes
// the decoder and the hazard block must agree on.
package core_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_KILL     = 2'd2
    } hz_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam int unsigned REG_W = 5;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare: a LOAD in EX whose non-x0 destination is read by ID.
module hazard_detect
    import core_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             ex_mem_to_reg_i,
    output logic             load_use_c
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit    = id_use_rs2_i && (id_rs2_i == ex_rd_i);
    assign load_use_c = ex_mem_to_reg_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: MEM handshake stalls, branch kill
// window, load-use bubbles, sticky memory timeout and a stall-cycle counter.
module pipeline_hazard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned BRANCH_PENALTY = 2,
    parameter int unsigned MEM_TIMEOUT    = 255,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_to_reg,
    input  logic             ex_redirect,
    input  logic             mem_access,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             bubble_ex,
    output logic             kill_if,
    output logic             pc_redirect,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned PEN_W  = 2;
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_e         state_q, state_d;
    logic [PEN_W-1:0]  pen_cnt_q, pen_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              pend_redir_q, pend_redir_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic load_use_c;
    logic timeout_c;
    logic mem_active_c;
    logic mem_stall_c;
    logic redirect_c;

    hazard_detect u_hazard_detect (
        .id_rs1_i        (id_rs1),
        .id_rs2_i        (id_rs2),
        .id_use_rs1_i    (id_use_rs1),
        .id_use_rs2_i    (id_use_rs2),
        .ex_rd_i         (ex_rd),
        .ex_mem_to_reg_i (ex_mem_to_reg),
        .load_use_c      (load_use_c)
    );

    // Next state and outputs; rst_n gates outputs so an abandoned access drops at once.
    always_comb begin
        state_d      = state_q;
        pen_cnt_d    = pen_cnt_q;
        wait_cnt_d   = '0;
        pend_redir_d = 1'b0;
        mem_err_d    = mem_err_q;
        dmem_req     = 1'b0;
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        stall_ex     = 1'b0;
        bubble_ex    = 1'b0;
        kill_if      = 1'b0;
        pc_redirect  = 1'b0;

        timeout_c    = (state_q == ST_MEM_WAIT) && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT));
        mem_active_c = (state_q == ST_MEM_WAIT) ? !timeout_c : mem_access;
        mem_stall_c  = mem_active_c && !dmem_ack;
        redirect_c   = !mem_stall_c && (ex_redirect || pend_redir_q);

        if (rst_n) begin
            dmem_req  = mem_active_c;
            mem_err_d = mem_err_q | timeout_c;
            if (mem_stall_c) begin
                stall_if     = 1'b1;
                stall_id     = 1'b1;
                stall_ex     = 1'b1;
                pend_redir_d = pend_redir_q | ex_redirect;
                if (state_q == ST_MEM_WAIT) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
                state_d = ST_MEM_WAIT;
            end else begin
                // A redirect kills the ID instruction, so it outranks load-use.
                if (redirect_c) begin
                    pc_redirect = 1'b1;
                    kill_if     = 1'b1;
                    bubble_ex   = 1'b1;
                    pen_cnt_d   = PEN_W'(BRANCH_PENALTY - 1);
                end else if (pen_cnt_q != '0) begin
                    kill_if   = 1'b1;
                    pen_cnt_d = pen_cnt_q - PEN_W'(1);
                end else if (load_use_c) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
                state_d = (pen_cnt_d != '0) ? ST_KILL : ST_RUN;
            end
        end

        stall_cnt_d = (stall_if && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            pen_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            pend_redir_q <= 1'b0;
            mem_err_q    <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pen_cnt_q    <= pen_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            pend_redir_q <= pend_redir_d;
            mem_err_q    <= mem_err_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule
